// File: rtl/sigrnd_pipe.sv
// sigrnd_pipe: two-stage significand rounder (double/single) with valid/ready flow control
module sigrnd_pipe #(
  parameter int SIG_W = 53,
  parameter int SP_SIG_W = 24,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic             db,
  input  logic [1:0]       rm,
  input  logic [SIG_W+1:0] f1,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W:0]   f2,
  output logic             siginx,
  output logic             sigovf,
  output logic [TAG_W-1:0] tag_out
);
  localparam int SH = SIG_W - SP_SIG_W;
  logic             s1_v, s2_v, s1_inc, s1_inx, s1_db;
  logic [SIG_W-1:0] s1_sig, sig;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_adv, s2_adv, l, r, st, inc;
  logic [SIG_W:0]   sum, res;
  always_comb begin
    sig = db ? f1[SIG_W+1:2] : {{SH{1'b0}}, f1[SIG_W+1 -: SP_SIG_W]};
    l = db ? f1[2] : f1[SH+2];
    r = db ? f1[1] : f1[SH+1];
    st = db ? f1[0] : |f1[SH:0];
    inc = rm == 2'b00 ? 1'b0 : rm == 2'b01 ? r & (l | st) : rm == 2'b10 ? ~s & (r | st) : s & (r | st);
    sum = {1'b0, s1_sig} + (SIG_W+1)'(s1_inc);
    res = s1_db ? sum : sum << SH;
  end
  assign s2_adv = ~s2_v | out_ready;
  assign s1_adv = ~s1_v | s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_sig <= '0;
      s1_inc <= 1'b0;
      s1_inx <= 1'b0;
      s1_db <= 1'b0;
      s1_tag <= '0;
      f2 <= '0;
      sigovf <= 1'b0;
      siginx <= 1'b0;
      tag_out <= '0;
    end else begin
      if (s1_adv) s1_v <= in_valid;
      if (s1_adv && in_valid) begin
        s1_sig <= sig;
        s1_inc <= inc;
        s1_inx <= r | st;
        s1_db <= db;
        s1_tag <= tag;
      end
      if (s2_adv) s2_v <= s1_v;
      if (s2_adv && s1_v) begin
        f2 <= res;
        sigovf <= res[SIG_W];
        siginx <= s1_inx;
        tag_out <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_sigrnd_pipe.sv
// tb_sigrnd_pipe: directed vectors, stall/reset sequences and randomized scoreboard run
module tb_sigrnd_pipe;
  localparam int SIG_W = 53;
  localparam int SP = 24;
  localparam int TAG_W = 4;
  localparam int SH = SIG_W - SP;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, s = 1'b0, db = 1'b1, out_ready = 1'b1;
  logic [1:0] rm = 2'b00;
  logic [SIG_W+1:0] f1 = '0;
  logic [TAG_W-1:0] tag = '0;
  logic in_ready, out_valid, siginx, sigovf;
  logic [SIG_W:0] f2;
  logic [TAG_W-1:0] tag_out;
  int n_cmp = 0, n_bad = 0;
  typedef struct { logic s, db; logic [1:0] rm; logic [SIG_W+1:0] f1; logic [SIG_W:0] f2; logic inx; } vec_t;
  typedef struct { logic [SIG_W:0] f2; logic inx; logic [TAG_W-1:0] tag; } exp_t;
  vec_t vt[11];
  exp_t q[$];
  sigrnd_pipe #(.SIG_W(SIG_W), .SP_SIG_W(SP), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .s(s), .db(db), .rm(rm),
    .f1(f1), .tag(tag), .out_valid(out_valid), .out_ready(out_ready), .f2(f2), .siginx(siginx),
    .sigovf(sigovf), .tag_out(tag_out));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic sg, input logic d, input logic [1:0] m, input logic [SIG_W+1:0] x);
    int k;
    logic [63:0] xx, sg_v, rem, half, f;
    logic inc;
    k = d ? 2 : SIG_W + 2 - SP;
    xx = 64'(x);
    sg_v = xx >> k;
    rem = xx & ((64'd1 << k) - 64'd1);
    half = 64'd1 << (k - 1);
    inc = m == 2'b00 ? 1'b0 : m == 2'b01 ? (rem > half || (rem == half && sg_v[0])) : (rem != 0) && (m == 2'b10 ? !sg : sg);
    f = (sg_v + 64'(inc)) << (d ? 0 : SH);
    f[63] = rem != 0;
    return f;
  endfunction
  task automatic run_vec(input int i);
    bit got;
    @(negedge clk);
    s = vt[i].s; db = vt[i].db; rm = vt[i].rm; f1 = vt[i].f1; tag = 4'(i); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        chk($sformatf("vec%0d_f2", i), 64'(f2), 64'(vt[i].f2));
        chk($sformatf("vec%0d_inx_ovf_tag", i), {58'd0, siginx, sigovf, tag_out}, {58'd0, vt[i].inx, vt[i].f2[SIG_W], 4'(i)});
      end
      @(negedge clk);
    end
    if (!got) chk($sformatf("vec%0d_timeout", i), 64'd0, 64'd1);
  endtask
  initial begin
    exp_t e;
    logic [63:0] m, held;
    logic [TAG_W-1:0] tg;
    int acc, k, first;
    bit have, prev_stall, drop;
    vt[0] = '{1'b0, 1'b1, 2'b01, 55'h0A, 54'h2, 1'b1};
    vt[1] = '{1'b0, 1'b1, 2'b01, 55'h0E, 54'h4, 1'b1};
    vt[2] = '{1'b0, 1'b1, 2'b00, 55'h0E, 54'h3, 1'b1};
    vt[3] = '{1'b0, 1'b1, 2'b10, 55'h05, 54'h2, 1'b1};
    vt[4] = '{1'b1, 1'b1, 2'b10, 55'h05, 54'h1, 1'b1};
    vt[5] = '{1'b1, 1'b1, 2'b11, 55'h05, 54'h2, 1'b1};
    vt[6] = '{1'b0, 1'b1, 2'b11, 55'h05, 54'h1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 2'b01, {{53{1'b1}}, 2'b10}, 54'h20000000000000, 1'b1};
    vt[8] = '{1'b0, 1'b0, 2'b01, {24'hFFFFFF, 31'h40000000}, 54'h20000000000000, 1'b1};
    vt[9] = '{1'b0, 1'b0, 2'b10, {24'h000001, 1'b0, 30'h1}, 54'h40000000, 1'b1};
    vt[10] = '{1'b1, 1'b1, 2'b11, 55'h10, 54'h4, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", {out_valid, in_ready, siginx, sigovf, tag_out, f2}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 54'd0});
    for (int i = 0; i < 11; i++) run_vec(i);
    // stall: three offered, two accepted, outputs frozen
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; db = 1'b1; rm = 2'b01; tg = 4'd1; tag = tg; acc = 0; have = 1'b0;
    for (int c = 0; c < 4; c++) begin
      f1 = 55'(c * 7 + 3);
      #1;
      if (out_valid) begin
        if (!have) begin held = {9'd0, tag_out, f2}; have = 1'b1; end
        else chk("stall_hold", {9'd0, tag_out, f2}, held);
      end
      if (in_ready) begin acc++; tg++; end
      @(negedge clk);
      tag = tg;
    end
    #1;
    chk("stall_accepted", 64'(acc), 64'd2);
    chk("stall_in_ready", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, 1'b1});
    chk("stall_tag_out", 64'(tag_out), 64'd1);
    @(negedge clk);
    out_ready = 1'b1; k = 0; first = 0; drop = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        if (k == 0) first = c;
        chk("order_tag", 64'(tag_out), 64'(k + 1));
        chk("order_gap", 64'(c - first), 64'(k));
        k++;
      end
      drop = in_valid && in_ready;
      @(negedge clk);
      if (drop) in_valid = 1'b0;
    end
    chk("order_count", 64'(k), 64'd3);
    // reset with two ops in flight
    out_ready = 1'b0; in_valid = 1'b1; f1 = 55'h0E;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("midrst_state", {out_valid, in_ready, siginx, sigovf, tag_out, f2}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 54'd0});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_emit", 64'(out_valid), 64'd0);
    end
    // randomized run against the arithmetic model
    prev_stall = 1'b0; held = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      s = 1'($urandom); db = 1'($urandom); rm = 2'($urandom); tag = 4'($urandom);
      f1 = (SIG_W + 2)'({$urandom, $urandom});
      k = int'($urandom_range(0, 7));
      if (k == 0) begin
        if (db) f1[1:0] = 2'b10;
        else f1[SH+1:0] = {1'b1, {(SH + 1){1'b0}}};
      end else if (k == 1) f1[SIG_W+1:2] = '1;
      #1;
      if (prev_stall) chk("rand_hold", {out_valid, sigovf, siginx, tag_out, f2}, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_spurious", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("rand_out", {3'd0, sigovf, siginx, tag_out, f2}, {3'd0, e.f2[SIG_W], e.inx, e.tag, e.f2});
        end
      end
      if (in_valid && in_ready) begin
        m = model(s, db, rm, f1);
        q.push_back('{m[SIG_W:0], m[63], tag});
      end
      prev_stall = out_valid && !out_ready;
      held = {out_valid, sigovf, siginx, tag_out, f2};
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("drain_spurious", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("drain_out", {3'd0, sigovf, siginx, tag_out, f2}, {3'd0, e.f2[SIG_W], e.inx, e.tag, e.f2});
        end
      end
      @(negedge clk);
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
